// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing sets and axis arithmetic for the raster generator.
package vga_pkg;

  typedef struct packed {
    int unsigned hactive;
    int unsigned hfp;
    int unsigned hsync;
    int unsigned hbp;
    int unsigned vactive;
    int unsigned vfp;
    int unsigned vsync;
    int unsigned vbp;
    logic        hpol;
    logic        vpol;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 = '{
    hactive: 640, hfp: 16, hsync: 96, hbp: 48,
    vactive: 480, vfp: 10, vsync: 2,  vbp: 33,
    hpol: 1'b0, vpol: 1'b0
  };

  localparam vga_timing_t VGA_800x600_72 = '{
    hactive: 800, hfp: 56, hsync: 120, hbp: 64,
    vactive: 600, vfp: 37, vsync: 6,   vbp: 23,
    hpol: 1'b1, vpol: 1'b1
  };

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; wrapping counter with active and sync decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int            TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT   = CW'(ACTIVE);
  localparam logic [CW-1:0] SS    = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SE    = CW'(ACTIVE + FP + SYNC - 1);

  assign wrap   = cnt == LAST;
  assign active = cnt < ACT;
  assign sync   = cnt >= SS && cnt <= SE;

  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (ce) cnt <= wrap ? '0 : cnt + CW'(1);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with a one-pixel registered output stage.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HACTIVE = int'(VGA_640x480_60.hactive),
  parameter int HFP     = int'(VGA_640x480_60.hfp),
  parameter int HSYNC   = int'(VGA_640x480_60.hsync),
  parameter int HBP     = int'(VGA_640x480_60.hbp),
  parameter int VACTIVE = int'(VGA_640x480_60.vactive),
  parameter int VFP     = int'(VGA_640x480_60.vfp),
  parameter int VSYNC   = int'(VGA_640x480_60.vsync),
  parameter int VBP     = int'(VGA_640x480_60.vbp),
  parameter bit HPOL    = VGA_640x480_60.hpol,
  parameter bit VPOL    = VGA_640x480_60.vpol,
  parameter int RW      = 3,
  parameter int GW      = 3,
  parameter int BW      = 2,
  parameter int CW      = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_ce,
  input  logic [RW-1:0] rin,
  input  logic [GW-1:0] gin,
  input  logic [BW-1:0] bin,
  output logic [RW-1:0] rout,
  output logic [GW-1:0] gout,
  output logic [BW-1:0] bout,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          frame_start,
  output logic          line_start,
  output logic          vblank
);

  localparam int HTOTAL = axis_total(HACTIVE, HFP, HSYNC, HBP);
  localparam int VTOTAL = axis_total(VACTIVE, VFP, VSYNC, VBP);

  if (CW < 1 || CW > 30 || HTOTAL > (1 << CW) || VTOTAL > (1 << CW) ||
      HACTIVE < 1 || HFP < 1 || HSYNC < 1 || HBP < 1 ||
      VACTIVE < 1 || VFP < 1 || VSYNC < 1 || VBP < 1 ||
      RW < 1 || GW < 1 || BW < 1) begin : g_bad_params
    $error("vga_timing_gen: illegal timing or width parameters");
  end

  logic h_wrap, h_act, h_sync, v_act, v_sync, v_wrap_unused;

  vga_axis_counter #(.ACTIVE(HACTIVE), .FP(HFP), .SYNC(HSYNC), .BP(HBP), .CW(CW)) u_h (
    .clk(clk), .rst(rst), .ce(pix_ce),
    .cnt(hc), .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );

  vga_axis_counter #(.ACTIVE(VACTIVE), .FP(VFP), .SYNC(VSYNC), .BP(VBP), .CW(CW)) u_v (
    .clk(clk), .rst(rst), .ce(pix_ce && h_wrap),
    .cnt(vc), .wrap(v_wrap_unused), .active(v_act), .sync(v_sync)
  );

  logic active;
  assign active = h_act && v_act;

  // Everything on the pins is the decode of the (hc, vc) that was current one pixel ago.
  always_ff @(posedge clk)
    if (rst) begin
      rout        <= '0;
      gout        <= '0;
      bout        <= '0;
      de          <= 1'b0;
      hs          <= ~HPOL;
      vs          <= ~VPOL;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      vblank      <= 1'b0;
    end else if (pix_ce) begin
      rout        <= active ? rin : '0;
      gout        <= active ? gin : '0;
      bout        <= active ? bin : '0;
      de          <= active;
      hs          <= h_sync ? HPOL : ~HPOL;
      vs          <= v_sync ? VPOL : ~VPOL;
      frame_start <= hc == '0 && vc == '0;
      line_start  <= hc == '0 && v_act;
      vblank      <= ~v_act;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized bench; three DUTs (small, small inverted polarity, default) vs a pixel-index model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pix_ce;
  logic [2:0] rin, gin;
  logic [1:0] bin;

  logic [3:0]       hc0, vc0, hc1, vc1;
  logic [10:0]      hc2, vc2;
  logic [2:0][2:0]  r, g;
  logic [2:0][1:0]  b;
  logic [2:0]       de, hs, vs, fs, ls, vb;

  int checks = 0, failures = 0;

  vga_timing_gen #(.HACTIVE(4), .HFP(1), .HSYNC(2), .HBP(1), .VACTIVE(3), .VFP(1), .VSYNC(1), .VBP(1),
                   .HPOL(1'b0), .VPOL(1'b0), .CW(4)) u_s0 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .rin(rin), .gin(gin), .bin(bin),
    .rout(r[0]), .gout(g[0]), .bout(b[0]), .hs(hs[0]), .vs(vs[0]), .de(de[0]),
    .hc(hc0), .vc(vc0), .frame_start(fs[0]), .line_start(ls[0]), .vblank(vb[0]));

  vga_timing_gen #(.HACTIVE(4), .HFP(1), .HSYNC(2), .HBP(1), .VACTIVE(3), .VFP(1), .VSYNC(1), .VBP(1),
                   .HPOL(1'b1), .VPOL(1'b1), .CW(4)) u_s1 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .rin(rin), .gin(gin), .bin(bin),
    .rout(r[1]), .gout(g[1]), .bout(b[1]), .hs(hs[1]), .vs(vs[1]), .de(de[1]),
    .hc(hc1), .vc(vc1), .frame_start(fs[1]), .line_start(ls[1]), .vblank(vb[1]));

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .rin(rin), .gin(gin), .bin(bin),
    .rout(r[2]), .gout(g[2]), .bout(b[2]), .hs(hs[2]), .vs(vs[2]), .de(de[2]),
    .hc(hc2), .vc(vc2), .frame_start(fs[2]), .line_start(ls[2]), .vblank(vb[2]));

  typedef struct packed {
    logic [10:0] hc, vc;
    logic [2:0]  r, g;
    logic [1:0]  b;
    logic        de, hs, vs, fs, ls, vb;
  } ob_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } cfg_t;

  // Model: pixels clocked since reset per DUT, and the colour captured at the last enabled edge.
  int         k[3];
  bit         valid, fix_rgb;
  logic [2:0] mr, mg;
  logic [1:0] mb;

  function automatic cfg_t cfg(input int i);
    cfg_t c;
    if (i == 2) c = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    else        c = '{4, 1, 2, 1, 3, 1, 1, 1, i == 1, i == 1};
    return c;
  endfunction

  function automatic ob_t expect_ob(input int i);
    cfg_t c = cfg(i);
    int ht = c.ha + c.hf + c.hs + c.hb;
    int vt = c.va + c.vf + c.vs + c.vb;
    int f = ht * vt;
    int q, h, v;
    bit act;
    ob_t e = '0;
    e.hc = 11'(k[i] % ht);
    e.vc = 11'(k[i] / ht);
    if (!valid) begin
      e.hs = !c.hp;
      e.vs = !c.vp;
      return e;
    end
    q = (k[i] + f - 1) % f;
    h = q % ht;
    v = q / ht;
    act = h < c.ha && v < c.va;
    e.de = act;
    e.r = act ? mr : 3'd0;
    e.g = act ? mg : 3'd0;
    e.b = act ? mb : 2'd0;
    e.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
    e.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : !c.vp;
    e.fs = q == 0;
    e.ls = h == 0 && v < c.va;
    e.vb = v >= c.va;
    return e;
  endfunction

  function automatic ob_t obs(input int i);
    ob_t o;
    o.hc = i == 0 ? 11'(hc0) : i == 1 ? 11'(hc1) : hc2;
    o.vc = i == 0 ? 11'(vc0) : i == 1 ? 11'(vc1) : vc2;
    o.r = r[i];
    o.g = g[i];
    o.b = b[i];
    o.de = de[i];
    o.hs = hs[i];
    o.vs = vs[i];
    o.fs = fs[i];
    o.ls = ls[i];
    o.vb = vb[i];
    return o;
  endfunction

  // Drive one clock's inputs, advance the model across the coming edge, settle at the next negedge.
  task automatic drive(input bit rv, input bit ce);
    rst = rv;
    pix_ce = ce;
    if (!fix_rgb) begin
      rin = 3'($urandom);
      gin = 3'($urandom);
      bin = 2'($urandom);
    end
    if (rv) begin
      valid = 1'b0;
      for (int i = 0; i < 3; i++) k[i] = 0;
    end else if (ce) begin
      valid = 1'b1;
      mr = rin;
      mg = gin;
      mb = bin;
      k[0] = (k[0] + 1) % 48;
      k[1] = (k[1] + 1) % 48;
      k[2] = (k[2] + 1) % 420000;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, n[0]);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== expect_ob(i)) begin
          failures++;
          $display("FAIL reset inst%0d got=%h exp=%h", i, obs(i), expect_ob(i));
        end
      end
    end
    checks++;
    if ({hs[0], vs[0], hs[1], vs[1]} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_sync_idle got=%b exp=1100", {hs[0], vs[0], hs[1], vs[1]});
    end
  endtask

  task automatic test_small_frame;
    int n_de = 0, n_fs = 0, n_ls = 0, n_r5 = 0, n_hs0 = 0, n_vs0 = 0, n_hs1 = 0, n_vb = 0;
    fix_rgb = 1'b1;
    rin = 3'b101;
    gin = 3'b010;
    bin = 2'b11;
    drive(1'b1, 1'b1);
    for (int n = 1; n <= 48; n++) begin
      drive(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== expect_ob(i)) begin
          failures++;
          $display("FAIL small_frame inst%0d cyc=%0d got=%h exp=%h", i, n, obs(i), expect_ob(i));
        end
      end
      if (n == 1) begin
        checks++;
        if ({fs[0], de[0]} !== 2'b11) begin
          failures++;
          $display("FAIL first_pixel fs,de got=%b exp=11", {fs[0], de[0]});
        end
      end
      n_de += int'(de[0]);
      n_fs += int'(fs[0]);
      n_ls += int'(ls[0]);
      n_r5 += int'(r[0] == 3'd5);
      n_hs0 += int'(!hs[0]);
      n_vs0 += int'(!vs[0]);
      n_hs1 += int'(hs[1]);
      n_vb += int'(vb[0]);
    end
    checks++;
    if ({n_de, n_fs, n_ls, n_r5, n_hs0, n_vs0, n_hs1, n_vb} !== {32'd12, 32'd1, 32'd3, 32'd12, 32'd12, 32'd8, 32'd12, 32'd24}) begin
      failures++;
      $display("FAIL frame_counts de=%0d fs=%0d ls=%0d r5=%0d hs0=%0d vs0=%0d hs1=%0d vb=%0d exp 12 1 3 12 12 8 12 24",
               n_de, n_fs, n_ls, n_r5, n_hs0, n_vs0, n_hs1, n_vb);
    end
    fix_rgb = 1'b0;
  endtask

  task automatic test_ce_toggle;
    int n_fs = 0;
    for (int n = 0; n < 96; n++) begin
      drive(1'b0, !n[0]);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== expect_ob(i)) begin
          failures++;
          $display("FAIL ce_toggle inst%0d cyc=%0d got=%h exp=%h", i, n, obs(i), expect_ob(i));
        end
      end
      if (!n[0]) n_fs += int'(fs[0]);
    end
    checks++;
    if (n_fs !== 1) begin
      failures++;
      $display("FAIL ce_toggle_frame_period fs_pulses=%0d exp=1", n_fs);
    end
  endtask

  task automatic test_mid_reset;
    drive(1'b1, 1'b1);
    for (int n = 0; n < 21; n++) drive(1'b0, 1'b1);
    checks++;
    if ({hc0, vc0} !== {4'd5, 4'd2}) begin
      failures++;
      $display("FAIL mid_reset_position got hc=%0d vc=%0d exp hc=5 vc=2", hc0, vc0);
    end
    drive(1'b1, 1'b0);
    checks++;
    if ({hc0, vc0, hs[0], vs[0], de[0]} !== {4'd0, 4'd0, 3'b110}) begin
      failures++;
      $display("FAIL mid_reset got hc=%0d vc=%0d hs=%b vs=%b de=%b exp 0 0 1 1 0", hc0, vc0, hs[0], vs[0], de[0]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs(i) !== expect_ob(i)) begin
        failures++;
        $display("FAIL mid_reset_model inst%0d got=%h exp=%h", i, obs(i), expect_ob(i));
      end
    end
    drive(1'b0, 1'b1);
    checks++;
    if ({fs[0], de[0], hc0} !== {2'b11, 4'd1}) begin
      failures++;
      $display("FAIL restart got fs=%b de=%b hc=%0d exp fs=1 de=1 hc=1", fs[0], de[0], hc0);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 5000; n++) begin
      drive($urandom_range(599) == 0, $urandom_range(3) != 0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== expect_ob(i)) begin
          failures++;
          $display("FAIL random inst%0d cyc=%0d got=%h exp=%h", i, n, obs(i), expect_ob(i));
        end
      end
    end
  endtask

  task automatic test_default_lines;
    int n_hs = 0, first_hc = -1, ls_at[$];
    drive(1'b1, 1'b1);
    for (int n = 1; n <= 2410; n++) begin
      drive(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== expect_ob(i)) begin
          failures++;
          $display("FAIL default_lines inst%0d cyc=%0d got=%h exp=%h", i, n, obs(i), expect_ob(i));
        end
      end
      if (n <= 800 && !hs[2]) begin
        n_hs++;
        if (first_hc < 0) first_hc = int'(hc2);
      end
      if (ls[2]) ls_at.push_back(n);
    end
    checks++;
    if (n_hs !== 96 || first_hc !== 657) begin
      failures++;
      $display("FAIL default_hsync width=%0d pin_hc_at_start=%0d exp width=96 pin_hc=657", n_hs, first_hc);
    end
    checks++;
    if (ls_at.size() !== 4 || ls_at[1] - ls_at[0] !== 800) begin
      failures++;
      $display("FAIL default_line_period starts=%0d exp=4", ls_at.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    pix_ce = 1'b0;
    rin = '0;
    gin = '0;
    bin = '0;
    valid = 1'b0;
    fix_rgb = 1'b0;
    mr = '0;
    mg = '0;
    mb = '0;
    for (int i = 0; i < 3; i++) k[i] = 0;
    @(negedge clk);
    test_reset;
    test_small_frame;
    test_ce_toggle;
    test_mid_reset;
    test_random;
    test_default_lines;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
